e203_exu_csr_xchctrl: RTL

//  Sequential CSR-instruction controller for the ALU CSR path. Local CSRs complete in 1 cycle.

---
 rtl/e203_exu_csr_xchctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/e203_exu_csr_xchctrl.sv
// CSR instruction controller: single-cycle local CSR file access, split request/response
// access to external CSR channels with timeout, and a one-entry result buffer for commit.
//
// state | meaning
// IDLE  | ready for a CSR instruction; local accesses complete here
// REQ   | external request presented to the selected channel
// RSP   | waiting for the channel response
// WB    | result held in obuf until commit takes it
//
// csr_i_info layout: [0] CSRRW [1] CSRRS [2] CSRRC [3] RS1IMM [4] RS1IS0 [9:5] ZIMM [21:10] CSRIDX
module e203_exu_csr_xchctrl #(
  parameter int         XLEN    = 32,
  parameter int         NCH     = 2,
  parameter logic [3:0] CH_BASE = 4'hC,
  parameter int         TMO_W   = 8,
  localparam int        DECINFO_W = 22,
  localparam int        CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csr_i_valid,
  output logic                  csr_i_ready,
  input  logic [XLEN-1:0]       csr_i_rs1,
  input  logic [DECINFO_W-1:0]  csr_i_info,
  input  logic                  csr_i_rdwen,
  output logic                  csr_ena,
  output logic                  csr_rd_en,
  output logic                  csr_wr_en,
  output logic [11:0]           csr_idx,
  input  logic                  csr_access_ilgl,
  input  logic [XLEN-1:0]       read_csr_dat,
  output logic [XLEN-1:0]       wbck_csr_dat,
  input  logic [NCH-1:0]        ch_off,
  output logic [NCH-1:0]        ext_req_valid,
  input  logic [NCH-1:0]        ext_req_ready,
  output logic [11:0]           ext_req_addr,
  output logic [1:0]            ext_req_op,
  output logic [XLEN-1:0]       ext_req_wdata,
  input  logic [NCH-1:0]        ext_rsp_valid,
  output logic [NCH-1:0]        ext_rsp_ready,
  input  logic [NCH*XLEN-1:0]   ext_rsp_rdata,
  input  logic [NCH-1:0]        ext_rsp_err,
  output logic                  csr_o_valid,
  input  logic                  csr_o_ready,
  output logic [XLEN-1:0]       csr_o_wbck_wdat,
  output logic                  csr_o_wbck_err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, WB} state_t;
  state_t state_q, state_nxt;

  logic            i_rw, i_rs, i_rc, i_imm, i_is0;
  logic [4:0]      i_zimm;
  logic [11:0]     i_idx;
  logic [XLEN-1:0] op1;
  logic [1:0]      ext_op;

  assign i_rw   = csr_i_info[0];
  assign i_rs   = csr_i_info[1];
  assign i_rc   = csr_i_info[2];
  assign i_imm  = csr_i_info[3];
  assign i_is0  = csr_i_info[4];
  assign i_zimm = csr_i_info[9:5];
  assign i_idx  = csr_i_info[21:10];
  assign op1    = i_imm ? {{(XLEN-5){1'b0}}, i_zimm} : csr_i_rs1;
  assign ext_op = i_rw ? 2'b00 : i_is0 ? 2'b11 : i_rs ? 2'b01 : 2'b10;

  logic [CHW-1:0]   ch_q, hit_ch;
  logic             ext_hit;
  logic [1:0]       op_q;
  logic [11:0]      addr_q;
  logic [XLEN-1:0]  wdata_q, obuf_dat_q;
  logic             obuf_err_q;
  logic [TMO_W-1:0] tmo_q;
  logic [NCH-1:0]   abandon_q, abandon_nxt;
  logic             req_rdy_sel, rsp_vld_sel, rsp_err_sel, aband_sel;
  logic [XLEN-1:0]  rdata_sel;
  logic             req_hs, rsp_hs, tmo_full;

  // A disabled channel falls through to the local CSR file.
  always_comb begin
    ext_hit = 1'b0;
    hit_ch  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (i_idx[11:8] == (CH_BASE + 4'(k)) && !ch_off[k]) begin
        ext_hit = 1'b1;
        hit_ch  = CHW'(k);
      end
    end
  end

  always_comb begin
    req_rdy_sel = 1'b0;
    rsp_vld_sel = 1'b0;
    rsp_err_sel = 1'b0;
    aband_sel   = 1'b0;
    rdata_sel   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CHW'(k)) begin
        req_rdy_sel = ext_req_ready[k];
        rsp_vld_sel = ext_rsp_valid[k];
        rsp_err_sel = ext_rsp_err[k];
        aband_sel   = abandon_q[k];
        rdata_sel   = ext_rsp_rdata[k*XLEN +: XLEN];
      end
    end
  end

  assign req_hs   = (state_q == REQ) && !aband_sel && req_rdy_sel;
  assign rsp_hs   = (state_q == RSP) && rsp_vld_sel;
  assign tmo_full = &tmo_q;

  // Abandoned channels get their late response drained; a response-phase timeout abandons.
  always_comb begin
    abandon_nxt = abandon_q & ~ext_rsp_valid;
    for (int k = 0; k < NCH; k++) begin
      if (state_q == RSP && !rsp_hs && tmo_full && ch_q == CHW'(k))
        abandon_nxt[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (csr_i_valid) state_nxt = ext_hit ? REQ : WB;
      REQ:  if (req_hs) state_nxt = RSP;
            else if (tmo_full) state_nxt = WB;
      RSP:  if (rsp_hs || tmo_full) state_nxt = WB;
      WB:   if (csr_o_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q       <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      obuf_dat_q <= '0;
      obuf_err_q <= 1'b0;
      tmo_q      <= '0;
      abandon_q  <= '0;
    end else begin
      abandon_q <= abandon_nxt;
      case (state_q)
        IDLE: if (csr_i_valid) begin
          if (ext_hit) begin
            ch_q    <= hit_ch;
            op_q    <= ext_op;
            addr_q  <= i_idx;
            wdata_q <= op1;
            tmo_q   <= '0;
          end else begin
            obuf_dat_q <= read_csr_dat;
            obuf_err_q <= csr_access_ilgl;
          end
        end
        REQ, RSP: begin
          if (req_hs) begin
            tmo_q <= '0;
          end else if (rsp_hs) begin
            obuf_dat_q <= rdata_sel;
            obuf_err_q <= rsp_err_sel;
          end else if (tmo_full) begin
            obuf_dat_q <= '0;
            obuf_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are qualified by rst_n so they read 0 while reset is held.
  always_comb begin
    csr_i_ready   = rst_n && (state_q == IDLE);
    csr_ena       = csr_i_ready && csr_i_valid && !ext_hit;
    csr_rd_en     = csr_ena && ((i_rw && csr_i_rdwen) || i_rs || i_rc);
    csr_wr_en     = csr_ena && (i_rw || ((i_rs || i_rc) && !i_is0));
    csr_idx       = i_idx;
    wbck_csr_dat  = i_rw ? op1 : i_rs ? (op1 | read_csr_dat) : (~op1 & read_csr_dat);
    ext_req_valid = '0;
    ext_rsp_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      ext_req_valid[k] = rst_n && (state_q == REQ) && (ch_q == CHW'(k)) && !abandon_q[k];
      ext_rsp_ready[k] = rst_n && (abandon_q[k] || ((state_q == RSP) && (ch_q == CHW'(k))));
    end
    ext_req_addr    = addr_q;
    ext_req_op      = op_q;
    ext_req_wdata   = wdata_q;
    csr_o_valid     = rst_n && (state_q == WB);
    csr_o_wbck_wdat = obuf_dat_q;
    csr_o_wbck_err  = obuf_err_q;
  end

endmodule
